// File: rtl/dac_player_pkg.sv
// Shared constants and state encoding for the AXI-Stream to SPI DAC playback path.
package dac_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_PLAY = 2'b10
    } state_e;

    localparam int unsigned FRAME_BITS       = 16;
    localparam logic [7:0]  CMD_PLAY_DEFAULT = 8'd112;
    localparam int unsigned MIN_DIV          = 36;

    // Frame cycle index of the last SCK toggle and of the last CS_N-low cycle.
    localparam logic [5:0]  SCK_LAST_CYC     = 6'd31;
    localparam logic [5:0]  FRAME_LAST_CYC   = 6'd33;

endpackage

// File: rtl/spi_dac_shifter.sv
// Shifts one 16-bit word out MSB first: SCK = clk/2 with 16 rising edges,
// SDI changing only while SCK is low, 34-cycle CS_N-low frame.
module spi_dac_shifter
    import dac_player_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] word,
    output logic                  cs_n,
    output logic                  sck,
    output logic                  sdi,
    output logic                  frame_done
);

    logic                  cs_n_q, cs_n_d;
    logic                  sck_q, sck_d;
    logic                  done_q, done_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [5:0]            cnt_q, cnt_d;

    // Frame sequencing: toggle SCK for 32 cycles, shift on each falling edge.
    always_comb begin
        cs_n_d = cs_n_q;
        sck_d  = sck_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (load) begin
            cs_n_d = 1'b0;
            sck_d  = 1'b0;
            sh_d   = word;
            cnt_d  = 6'd0;
        end else if (!cs_n_q) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q <= SCK_LAST_CYC) begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    sh_d = {sh_q[FRAME_BITS-2:0], 1'b0};
                end else begin
                    sh_d = sh_q;
                end
            end else begin
                sck_d = 1'b0;
            end
            if (cnt_q == FRAME_LAST_CYC) begin
                cs_n_d = 1'b1;
                done_d = 1'b1;
                cnt_d  = 6'd0;
            end else begin
                cs_n_d = 1'b0;
            end
        end else begin
            cnt_d = 6'd0;
        end
    end

    // Frame state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n_q <= 1'b1;
            sck_q  <= 1'b0;
            sh_q   <= '0;
            cnt_q  <= 6'd0;
            done_q <= 1'b0;
        end else begin
            cs_n_q <= cs_n_d;
            sck_q  <= sck_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cs_n       = cs_n_q;
    assign sck        = sck_q;
    assign sdi        = sh_q[FRAME_BITS-1];
    assign frame_done = done_q;

endmodule

// File: rtl/axis_spi_dac_player.sv
// Waits for a play command, loads DEPTH little-endian samples from the host
// byte stream into a buffer, then replays them to an SPI DAC at sample_rate.
module axis_spi_dac_player
    import dac_player_pkg::*;
#(
    parameter int unsigned WIDTH       = 14,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned clk_freq    = 4000000,
    parameter int unsigned sample_rate = 100000,
    parameter logic [7:0]  CMD_PLAY    = CMD_PLAY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_tdata,
    input  logic       i_tvalid,
    output logic       i_tready,
    output logic       o_busy,
    output logic       o_done,
    output logic       DAC_CS_N,
    output logic       DAC_SCK,
    output logic       DAC_SDI
);

    localparam int unsigned DIV = clk_freq / sample_rate;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned DW  = $clog2(DIV);

    if (DIV < MIN_DIV) begin : g_div_chk
        $error("axis_spi_dac_player: clk_freq/sample_rate must be at least 36");
    end
    if (WIDTH > FRAME_BITS) begin : g_width_chk
        $error("axis_spi_dac_player: WIDTH must not exceed 16");
    end

    state_e                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  phase_q, phase_d;
    logic [7:0]            lo_q, lo_d;
    logic [DW-1:0]         div_q, div_d;
    logic                  last_q, last_d;
    logic                  tready_q, tready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  load_q, load_d;
    logic                  accept, tick, wr_en, illegal, frame_done;
    logic [15:0]           pair;
    logic [WIDTH-1:0]      wr_data;
    logic [WIDTH-1:0]      rd_data_q;
    logic [FRAME_BITS-1:0] word;
    logic [WIDTH-1:0]      buf_mem [DEPTH];
    logic                  unused_pair;

    assign unused_pair = ^pair;

    // Next-state, pointer and handshake logic.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        phase_d  = phase_q;
        lo_d     = lo_q;
        div_d    = div_q;
        last_d   = last_q;
        done_d   = 1'b0;
        load_d   = 1'b0;
        wr_en    = 1'b0;
        tick     = 1'b0;
        illegal  = 1'b0;
        accept   = i_tvalid & tready_q;
        pair     = {i_tdata, lo_q};
        wr_data  = pair[WIDTH-1:0];
        case (state_q)
            ST_IDLE: begin
                if (accept && (i_tdata == CMD_PLAY)) begin
                    state_d  = ST_LOAD;
                    phase_d  = 1'b0;
                    wr_ptr_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept && !phase_q) begin
                    lo_d    = i_tdata;
                    phase_d = 1'b1;
                end else if (accept) begin
                    wr_en    = 1'b1;
                    phase_d  = 1'b0;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == AW'(DEPTH - 1)) begin
                        state_d  = ST_PLAY;
                        div_d    = '0;
                        rd_ptr_d = '0;
                        last_d   = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_PLAY: begin
                // No further ticks once the final sample has been read.
                tick   = (div_q == '0) && !last_q;
                div_d  = (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);
                load_d = tick;
                if (tick) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    last_d   = (rd_ptr_q == AW'(DEPTH - 1));
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
                if (frame_done && last_q) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                phase_d  = 1'b0;
                div_d    = '0;
                last_d   = 1'b0;
                illegal  = 1'b1;
            end
        endcase
        tready_d = !illegal && ((state_d == ST_IDLE) || (state_d == ST_LOAD));
        busy_d   = !illegal && ((state_d == ST_LOAD) || (state_d == ST_PLAY));
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            phase_q  <= 1'b0;
            lo_q     <= 8'd0;
            div_q    <= '0;
            last_q   <= 1'b0;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            phase_q  <= phase_d;
            lo_q     <= lo_d;
            div_q    <= div_d;
            last_q   <= last_d;
            tready_q <= tready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            load_q   <= load_d;
        end
    end

    // Sample buffer: contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_ptr_q] <= wr_data;
        end
        if (tick) begin
            rd_data_q <= buf_mem[rd_ptr_q];
        end
    end

    // Zero-extend the sample into the 16-bit DAC word.
    always_comb begin
        word             = '0;
        word[WIDTH-1:0]  = rd_data_q;
    end

    spi_dac_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (load_q),
        .word       (word),
        .cs_n       (DAC_CS_N),
        .sck        (DAC_SCK),
        .sdi        (DAC_SDI),
        .frame_done (frame_done)
    );

    assign i_tready = tready_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_axis_spi_dac_player.sv
// Randomised bench: loads sample frames over the byte stream and decodes the
// SPI pins back into words, comparing against the loaded samples.
module tb_axis_spi_dac_player;

    localparam int WIDTH = 14;
    localparam int DEPTH = 32;
    localparam int DIV   = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_tdata = 8'd0;
    logic       i_tvalid = 1'b0;
    logic       i_tready, o_busy, o_done, DAC_CS_N, DAC_SCK, DAC_SDI;

    always #5 clk = ~clk;

    axis_spi_dac_player #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .clk_freq    (4000000),
        .sample_rate (100000),
        .CMD_PLAY    (8'd112)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_tdata  (i_tdata),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .DAC_CS_N (DAC_CS_N),
        .DAC_SCK  (DAC_SCK),
        .DAC_SDI  (DAC_SDI)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [15:0] smp [DEPTH];
    logic [15:0] got_q [$];
    int          last_fall_cyc = -1;
    int          last_rise_cyc = 0;
    int          fall_cyc = 0;
    int          edges = 0;
    bit          in_frame = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SPI decoder sampling the pins on the falling clk edge.
    initial begin
        logic        prev_cs  = 1'b1;
        logic        prev_sck = 1'b0;
        logic        prev_sdi = 1'b0;
        logic [15:0] sh = 16'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                if (!DAC_CS_N && prev_cs) begin
                    if (last_fall_cyc >= 0) check("cs_period", cyc - last_fall_cyc, DIV);
                    last_fall_cyc = cyc;
                    fall_cyc = cyc;
                    in_frame = 1'b1;
                    edges = 0;
                    sh = 16'd0;
                end
                if (in_frame && !DAC_CS_N) begin
                    if (DAC_SCK && !prev_sck) begin
                        sh = {sh[14:0], DAC_SDI};
                        edges++;
                    end
                    if (DAC_SDI !== prev_sdi) check("sdi_moves_with_sck_low", DAC_SCK, 1'b0);
                end
                if (in_frame && DAC_CS_N && !prev_cs) begin
                    check("sck_rising_edges", edges, 16);
                    check("frame_len", cyc - fall_cyc, 34);
                    got_q.push_back(sh);
                    last_rise_cyc = cyc;
                    in_frame = 1'b0;
                end
            end
            prev_cs  = DAC_CS_N;
            prev_sck = DAC_SCK;
            prev_sdi = DAC_SDI;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_tdata  = b;
        i_tvalid = 1'b1;
        while (i_tready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("tready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        i_tvalid = 1'b0;
    endtask

    task automatic arm_and_load(input string tag);
        got_q.delete();
        last_fall_cyc = -1;
        send_byte(8'h70);
        check({tag, "_busy_after_cmd"}, o_busy, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            send_byte(smp[k][7:0]);
            if (k == 0) check({tag, "_still_loading"}, i_tready, 1'b1);
            send_byte(smp[k][15:8]);
        end
        check({tag, "_tready_drop"}, i_tready, 1'b0);
        check({tag, "_busy_play"}, o_busy, 1'b1);
    endtask

    task automatic wait_play(input string tag);
        int n = 0;
        int done_cnt = 0;
        int done_cyc = 0;
        int lim = DEPTH * DIV + 200;
        while (o_busy === 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
            if (o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        check({tag, "_play_timeout"}, (n < lim), 1'b1);
        repeat (3) begin
            @(negedge clk);
            if (o_done === 1'b1) done_cnt++;
        end
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_after_last_rise"}, (done_cyc > last_rise_cyc), 1'b1);
        check({tag, "_tready_idle"}, i_tready, 1'b1);
        check({tag, "_frame_count"}, got_q.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
            check({tag, "_word"}, got_q[i], smp[i] % (1 << WIDTH));
        end
    endtask

    initial begin
        int n;
        repeat (5) @(negedge clk);
        check("tready_in_reset", i_tready, 1'b0);
        check("cs_in_reset", DAC_CS_N, 1'b1);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_tready", i_tready, 1'b1);
        check("idle_cs", DAC_CS_N, 1'b1);
        check("idle_sck", DAC_SCK, 1'b0);
        check("idle_busy", o_busy, 1'b0);
        check("idle_no_frames", got_q.size(), 0);

        send_byte(8'h41);
        repeat (3) @(negedge clk);
        check("ignored_byte_busy", o_busy, 1'b0);
        check("ignored_byte_tready", i_tready, 1'b1);

        // Ramp
        for (int k = 0; k < DEPTH; k++) smp[k] = 16'(k);
        arm_and_load("ramp");
        wait_play("ramp");

        // Full-scale words with upper bits that must be dropped
        for (int k = 0; k < DEPTH; k++) smp[k] = 16'hFFFF;
        arm_and_load("ones");
        wait_play("ones");

        // Random data with the command byte embedded as data
        for (int k = 0; k < DEPTH; k++) smp[k] = 16'($urandom);
        smp[5] = 16'h0070;
        smp[9] = 16'h7070;
        arm_and_load("cmd_data");
        wait_play("cmd_data");
        repeat (50) @(negedge clk);
        check("no_rearm_busy", o_busy, 1'b0);
        check("no_rearm_frames", got_q.size(), DEPTH);

        // Reset in the middle of the frame for sample 10
        for (int k = 0; k < DEPTH; k++) smp[k] = 16'($urandom);
        arm_and_load("pre_rst");
        n = 0;
        while (!(got_q.size() == 10 && in_frame && edges >= 7) && n < DEPTH * DIV) begin
            @(negedge clk);
            n++;
        end
        check("rst_trigger_found", (n < DEPTH * DIV), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cs", DAC_CS_N, 1'b1);
        check("rst_sck", DAC_SCK, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", i_tready, 1'b1);

        for (int k = 0; k < DEPTH; k++) smp[k] = 16'($urandom);
        arm_and_load("after_rst");
        wait_play("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
